// File: rtl/match_result_drain.sv
`default_nettype none
// ============================================================================
// match_result_drain
//   Buffers up to two batches of lane hit bits and serialises every set bit
//   into a global matched-weight index stream; pulses done after the last batch.
//   Optional build macro: MATCH_DRAIN_ZERO_SKIP_EN (drop empty non-last batches).
// Revision: 1.0
// ============================================================================
module match_result_drain #(
    parameter int LANES      = 256,
    parameter int WEIGHT_NUM = 23331,
    parameter int IDXW       = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_hits,
    input  logic [IDXW-1:0]  in_base,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_index,
    output logic [IDXW:0]    hit_total,
    output logic             done
);

    localparam int             POSW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [0:0]     ST_IDLE  = 1'b0;
    localparam logic [0:0]     ST_SCAN  = 1'b1;
    localparam logic [IDXW:0]  WNUM     = (IDXW+1)'(WEIGHT_NUM);
    localparam logic [IDXW:0]  HIT_ONE  = (IDXW+1)'(1);
    localparam logic [LANES-1:0] LANE_ONE = LANES'(1);

    // Capture side
    logic [LANES-1:0] lane_mask;
    logic [LANES-1:0] masked_hits;
    logic             skip;
    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    // Widened compare so a base near the top of the index range cannot wrap.
    for (genvar k = 0; k < LANES; k++) begin : g_lane_mask
        assign lane_mask[k] = ({1'b0, in_base} + (IDXW+1)'(k)) < WNUM;
    end

    assign masked_hits = in_hits & lane_mask;

`ifdef MATCH_DRAIN_ZERO_SKIP_EN
    assign skip = (masked_hits == '0) && !in_last;
`else
    assign skip = 1'b0;
`endif

    // Two-entry FIFO
    logic [LANES-1:0] fifo_mask_q [2];
    logic [IDXW-1:0]  fifo_base_q [2];
    logic             fifo_last_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    assign in_ready   = (count_q != 2'd2);
    assign fifo_empty = (count_q == 2'd0);
    assign accept     = in_valid && in_ready;
    assign push       = accept && !skip;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mask_q[wr_ptr_q] <= masked_hits;
            fifo_base_q[wr_ptr_q] <= in_base;
            fifo_last_q[wr_ptr_q] <= in_last;
        end
    end

    // Scanner
    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [LANES-1:0] mask_q;
    logic [LANES-1:0] mask_after;
    logic [IDXW-1:0]  base_q;
    logic             last_q;
    logic [POSW-1:0]  pos;
    logic             handshake;
    logic             finish;
    logic             done_q;
    logic             done_d;
    logic             clear_pend_q;
    logic [IDXW:0]    hit_q;
    logic [IDXW:0]    hit_base;
    logic [IDXW:0]    hit_d;

    // Descending walk leaves the lowest set bit in pos.
    always_comb begin
        pos = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_q[i]) pos = POSW'(i);
        end
    end

    assign mask_after = handshake ? (mask_q & (mask_q - LANE_ONE)) : mask_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty)        state_d = ST_SCAN;
            ST_SCAN: if (mask_after == '0)   state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_SCAN) && (mask_q != '0);
        handshake = out_valid && out_ready;
        pop       = (state_q == ST_IDLE) && !fifo_empty;
        finish    = (state_q == ST_SCAN) && (mask_after == '0);
        done_d    = finish && last_q;
    end

    assign out_index = base_q + IDXW'(pos);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            base_q <= '0;
            last_q <= 1'b0;
        end else if (pop) begin
            mask_q <= fifo_mask_q[rd_ptr_q];
            base_q <= fifo_base_q[rd_ptr_q];
            last_q <= fifo_last_q[rd_ptr_q];
        end else if (state_q == ST_SCAN) begin
            mask_q <= mask_after;
        end
    end

    // The total restarts on the first acceptance after a run completes.
    assign hit_base = (accept && clear_pend_q) ? '0 : hit_q;
    assign hit_d    = (handshake && (hit_base != '1)) ? hit_base + HIT_ONE : hit_base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q        <= '0;
            done_q       <= 1'b0;
            clear_pend_q <= 1'b0;
        end else begin
            hit_q        <= hit_d;
            done_q       <= done_d;
            clear_pend_q <= done_d || (clear_pend_q && !accept);
        end
    end

    assign hit_total = hit_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_match_result_drain.sv
`default_nettype none
// ============================================================================
// tb_match_result_drain
//   Randomised self-checking bench; expected index streams come from a
//   set-bit enumeration model of each batch.
// Revision: 1.0
// ============================================================================
module tb_match_result_drain;

    localparam int LANES      = 256;
    localparam int WEIGHT_NUM = 23331;
    localparam int IDXW       = 15;
    localparam int BUDGET     = 4000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [LANES-1:0] in_hits = '0;
    logic [IDXW-1:0]  in_base = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [IDXW-1:0]  out_index;
    logic [IDXW:0]    hit_total;
    logic             done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [IDXW-1:0] exp_q[$];
    logic [IDXW-1:0] obs_q[$];
    int              hs_cyc_q[$];
    bit              smp_v[$];
    bit              smp_r[$];
    logic [IDXW-1:0] smp_i[$];
    int              done_cnt;
    int              done_cyc;
    bit              col_to;
    int              max_valid;
    int              pat[5] = '{1, 0, 0, 1, 1};

    match_result_drain #(
        .LANES      (LANES),
        .WEIGHT_NUM (WEIGHT_NUM),
        .IDXW       (IDXW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_hits   (in_hits),
        .in_base   (in_base),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .hit_total (hit_total),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference model: every lane whose bit is set and whose global index exists.
    task automatic model_batch(input logic [LANES-1:0] h, input logic [IDXW-1:0] b);
        for (int k = 0; k < LANES; k++) begin
            if (h[k] && (int'(b) + k) < WEIGHT_NUM) exp_q.push_back(IDXW'(int'(b) + k));
        end
    endtask

    function automatic logic [LANES-1:0] rand_hits();
        logic [LANES-1:0] r;
        for (int w = 0; w < LANES / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_batch(input logic [LANES-1:0] h, input logic [IDXW-1:0] b,
                              input logic l, output int acc_cyc, output bit to);
        in_valid = 1'b1;
        in_hits  = h;
        in_base  = b;
        in_last  = l;
        to       = 1'b0;
        acc_cyc  = -1;
        for (int n = 0; !in_ready; n++) begin
            if (n >= BUDGET) begin
                to = 1'b1;
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    // mode 0: always ready, 1: pattern by valid-cycle count, 2: random ready.
    task automatic collect(input int mode);
        int vcnt;
        bit rdy;
        obs_q.delete(); hs_cyc_q.delete();
        smp_v.delete(); smp_r.delete(); smp_i.delete();
        done_cnt = 0; done_cyc = -1; col_to = 1'b0; vcnt = 0; max_valid = 0;
        for (int n = 0; n < BUDGET; n++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (vcnt < 5) ? (pat[vcnt] != 0) : 1'b1;
            else                rdy = (($urandom % 4) != 0);
            out_ready = rdy;
            smp_v.push_back(out_valid);
            smp_i.push_back(out_index);
            smp_r.push_back(rdy);
            if (out_valid) begin
                max_valid = 1;
                vcnt++;
                if (rdy) begin
                    obs_q.push_back(out_index);
                    hs_cyc_q.push_back(cyc);
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) return;
            @(negedge clk);
        end
        col_to = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_index !== '0)   begin failures++; $display("FAIL reset_out_index got=%0d want=0", out_index); end
        checks++; if (hit_total !== '0)   begin failures++; $display("FAIL reset_hit_total got=%0d want=0", hit_total); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_base_case();
        logic [LANES-1:0] h;
        int acc; bit to; int bad;
        h = '0; h[0] = 1'b1; h[5] = 1'b1; h[255] = 1'b1;
        exp_q.delete(); model_batch(h, '0);
        send_batch(h, '0, 1'b1, acc, to);
        in_valid = 1'b0;
        collect(0);
        checks++; if (to || col_to) begin failures++; $display("FAIL base_timeout got=%0d/%0d want=0/0", to, col_to); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL base_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        bad = -1;
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) if (bad < 0 && obs_q[k] !== exp_q[k]) bad = k;
        checks++; if (bad >= 0) begin failures++; $display("FAIL base_order idx=%0d got=%0d want=%0d", bad, obs_q[bad], exp_q[bad]); end
        if (hs_cyc_q.size() == 3) begin
            checks++; if (hs_cyc_q[0] != acc + 1) begin failures++; $display("FAIL base_latency got=%0d want=%0d", hs_cyc_q[0], acc + 1); end
            checks++; if (hs_cyc_q[2] - hs_cyc_q[0] != 2) begin failures++; $display("FAIL base_consecutive got=%0d want=2", hs_cyc_q[2] - hs_cyc_q[0]); end
            checks++; if (done_cyc != hs_cyc_q[2] + 1) begin failures++; $display("FAIL base_done_cycle got=%0d want=%0d", done_cyc, hs_cyc_q[2] + 1); end
        end
        checks++; if (hit_total !== 16'd3) begin failures++; $display("FAIL base_hit_total got=%0d want=3", hit_total); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL base_done_pulses got=%0d want=1", done_cnt); end
    endtask

    task automatic test_backpressure();
        logic [LANES-1:0] h;
        int acc; bit to; int bad; int stalls5; int unstable;
        h = '0; h[0] = 1'b1; h[5] = 1'b1; h[255] = 1'b1;
        exp_q.delete(); model_batch(h, '0);
        send_batch(h, '0, 1'b1, acc, to);
        in_valid = 1'b0;
        collect(1);
        checks++; if (to || col_to) begin failures++; $display("FAIL bp_timeout got=%0d/%0d want=0/0", to, col_to); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        bad = -1;
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) if (bad < 0 && obs_q[k] !== exp_q[k]) bad = k;
        checks++; if (bad >= 0) begin failures++; $display("FAIL bp_order idx=%0d got=%0d want=%0d", bad, obs_q[bad], exp_q[bad]); end
        stalls5 = 0; unstable = 0;
        for (int j = 0; j + 1 < smp_v.size(); j++) begin
            if (smp_v[j] && !smp_r[j]) begin
                if (smp_i[j] == 15'd5) stalls5++;
                if (!smp_v[j+1] || smp_i[j+1] !== smp_i[j]) unstable++;
            end
        end
        checks++; if (stalls5 != 2) begin failures++; $display("FAIL bp_stall_index5 got=%0d want=2", stalls5); end
        checks++; if (unstable != 0) begin failures++; $display("FAIL bp_hold_stable got=%0d want=0", unstable); end
        checks++; if (hit_total !== 16'd3) begin failures++; $display("FAIL bp_hit_total got=%0d want=3", hit_total); end
    endtask

    task automatic test_tail_mask();
        int acc; bit to; int bad; int over;
        exp_q.delete(); model_batch('1, 15'd23296);
        send_batch('1, 15'd23296, 1'b1, acc, to);
        in_valid = 1'b0;
        collect(2);
        checks++; if (to || col_to) begin failures++; $display("FAIL tail_timeout got=%0d/%0d want=0/0", to, col_to); end
        checks++; if (obs_q.size() != 35) begin failures++; $display("FAIL tail_count got=%0d want=35", obs_q.size()); end
        bad = -1; over = 0;
        for (int k = 0; k < obs_q.size(); k++) begin
            if (int'(obs_q[k]) >= WEIGHT_NUM) over++;
            if (bad < 0 && k < exp_q.size() && obs_q[k] !== exp_q[k]) bad = k;
        end
        checks++; if (bad >= 0) begin failures++; $display("FAIL tail_order idx=%0d got=%0d want=%0d", bad, obs_q[bad], exp_q[bad]); end
        checks++; if (over != 0) begin failures++; $display("FAIL tail_out_of_range got=%0d want=0", over); end
        checks++; if (hit_total !== 16'd35) begin failures++; $display("FAIL tail_hit_total got=%0d want=35", hit_total); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL tail_done_pulses got=%0d want=1", done_cnt); end
    endtask

    task automatic test_empty_last();
        int acc; bit to;
        send_batch('0, 15'($urandom_range(0, 23000)), 1'b1, acc, to);
        in_valid = 1'b0;
        collect(0);
        checks++; if (to || col_to) begin failures++; $display("FAIL empty_timeout got=%0d/%0d want=0/0", to, col_to); end
        checks++; if (max_valid != 0) begin failures++; $display("FAIL empty_out_valid got=%0d want=0", max_valid); end
        checks++; if (done_cyc - acc != 2) begin failures++; $display("FAIL empty_done_latency got=%0d want=2", done_cyc - acc); end
        checks++; if (hit_total !== '0) begin failures++; $display("FAIL empty_hit_total got=%0d want=0", hit_total); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL empty_done_pulses got=%0d want=1", done_cnt); end
    endtask

    task automatic test_full_fifo();
        logic [LANES-1:0] h [4];
        logic [IDXW-1:0]  b [4];
        int acc[4]; bit to[4]; int bad; int n0; int blocked; int held;
        logic [IDXW-1:0] first_idx;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            h[i] = rand_hits() & rand_hits();
            b[i] = 15'($urandom_range(0, 20000));
        end
        h[0][0] = 1'b1;
        model_batch(h[0], b[0]); n0 = exp_q.size();
        for (int i = 1; i < 4; i++) model_batch(h[i], b[i]);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_batch(h[i], b[i], 1'b0, acc[i], to[i]);
        in_hits = h[3]; in_base = b[3]; in_last = 1'b1;
        first_idx = out_index;
        blocked = 0; held = 0;
        for (int n = 0; n < 6; n++) begin
            if (in_ready !== 1'b0) blocked++;
            if (out_valid !== 1'b1 || out_index !== first_idx) held++;
            @(negedge clk);
        end
        checks++; if (to[0] || to[1] || to[2]) begin failures++; $display("FAIL full_fill_timeout got=%0d%0d%0d want=000", to[0], to[1], to[2]); end
        checks++; if (blocked != 0) begin failures++; $display("FAIL full_in_ready_low got=%0d want=0", blocked); end
        checks++; if (held != 0 || first_idx !== exp_q[0]) begin failures++; $display("FAIL full_head_hold got=%0d/%0d want=0/%0d", held, first_idx, exp_q[0]); end
        fork
            collect(2);
            begin
                send_batch(h[3], b[3], 1'b1, acc[3], to[3]);
                in_valid = 1'b0;
            end
        join
        checks++; if (to[3] || col_to) begin failures++; $display("FAIL full_timeout got=%0d/%0d want=0/0", to[3], col_to); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL full_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        bad = -1;
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) if (bad < 0 && obs_q[k] !== exp_q[k]) bad = k;
        checks++; if (bad >= 0) begin failures++; $display("FAIL full_order idx=%0d got=%0d want=%0d", bad, obs_q[bad], exp_q[bad]); end
        if (hs_cyc_q.size() >= n0) begin
            checks++; if (acc[3] <= hs_cyc_q[n0-1]) begin failures++; $display("FAIL full_accept_after_pop got=%0d want>%0d", acc[3], hs_cyc_q[n0-1]); end
        end
        checks++; if (int'(hit_total) != exp_q.size()) begin failures++; $display("FAIL full_hit_total got=%0d want=%0d", hit_total, exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int nb; int bad; int acc; bit to; bit any_to;
        logic [LANES-1:0] h [4];
        logic [IDXW-1:0]  b [4];
        for (int run = 0; run < 4; run++) begin
            nb = $urandom_range(1, 4);
            exp_q.delete();
            for (int i = 0; i < nb; i++) begin
                h[i] = rand_hits() & rand_hits() & rand_hits();
                if (($urandom % 5) == 0) h[i] = '0;
                b[i] = 15'($urandom_range(0, 23400));
                model_batch(h[i], b[i]);
            end
            any_to = 1'b0;
            fork
                collect(2);
                begin
                    for (int i = 0; i < nb; i++) begin
                        send_batch(h[i], b[i], (i == nb - 1), acc, to);
                        any_to |= to;
                    end
                    in_valid = 1'b0;
                end
            join
            checks++; if (any_to || col_to) begin failures++; $display("FAIL b2b_timeout run=%0d got=%0d/%0d want=0/0", run, any_to, col_to); end
            checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count run=%0d got=%0d want=%0d", run, obs_q.size(), exp_q.size()); end
            bad = -1;
            for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) if (bad < 0 && obs_q[k] !== exp_q[k]) bad = k;
            checks++; if (bad >= 0) begin failures++; $display("FAIL b2b_order run=%0d idx=%0d got=%0d want=%0d", run, bad, obs_q[bad], exp_q[bad]); end
            checks++; if (int'(hit_total) != exp_q.size()) begin failures++; $display("FAIL b2b_hit_total run=%0d got=%0d want=%0d", run, hit_total, exp_q.size()); end
            checks++; if (done_cnt != 1) begin failures++; $display("FAIL b2b_done_pulses run=%0d got=%0d want=1", run, done_cnt); end
        end
    endtask

    task automatic test_mid_reset();
        logic [LANES-1:0] h;
        logic [IDXW-1:0]  b;
        int acc; bit to; int hs; int bad; int spurious;
        h = '0; h[3] = 1'b1; h[40] = 1'b1; h[100] = 1'b1; h[200] = 1'b1;
        b = 15'($urandom_range(0, 20000));
        send_batch(h, b, 1'b1, acc, to);
        in_valid = 1'b0;
        out_ready = 1'b1;
        hs = 0;
        for (int n = 0; n < 50 && hs < 2; n++) begin
            if (out_valid) hs++;
            @(posedge clk);
            if (hs < 2) @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (hs != 2) begin failures++; $display("FAIL mrst_handshakes got=%0d want=2", hs); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mrst_in_ready got=%b want=1", in_ready); end
        checks++; if (hit_total !== '0) begin failures++; $display("FAIL mrst_hit_total got=%0d want=0", hit_total); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        spurious = 0;
        for (int n = 0; n < 6; n++) begin
            if (done !== 1'b0 || out_valid !== 1'b0) spurious++;
            @(negedge clk);
        end
        checks++; if (spurious != 0) begin failures++; $display("FAIL mrst_no_done got=%0d want=0", spurious); end
        h = '0; h[7] = 1'b1; h[8] = 1'b1; h[250] = 1'b1;
        exp_q.delete(); model_batch(h, b);
        send_batch(h, b, 1'b1, acc, to);
        in_valid = 1'b0;
        collect(0);
        checks++; if (to || col_to) begin failures++; $display("FAIL mrst_timeout got=%0d/%0d want=0/0", to, col_to); end
        bad = (obs_q.size() != exp_q.size()) ? 0 : -1;
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) if (bad < 0 && obs_q[k] !== exp_q[k]) bad = k;
        checks++; if (bad >= 0) begin failures++; $display("FAIL mrst_order count=%0d want_count=%0d first_bad=%0d", obs_q.size(), exp_q.size(), bad); end
        checks++; if (hit_total !== 16'd3) begin failures++; $display("FAIL mrst_hit_total got=%0d want=3", hit_total); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL mrst_done_pulses got=%0d want=1", done_cnt); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_base_case();
        test_backpressure();
        test_tail_mask();
        test_empty_last();
        test_full_fifo();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/match_result_drain.md
Name: match_result_drain

Overview:
- Downstream consumer of the PE-array match vector (per-lane `out_down` hits gathered by the routers, one bit per weight lane).
- Accepts one batch of LANES hit bits plus the global weight index of lane 0, and buffers up to 2 batches.
- Serialises every set bit into a global matched-weight index on a valid/ready stream, keeps a running hit total, and pulses done after the final batch drains.

Parameters:
- LANES, 256: hit bits per batch (num*groups).
- WEIGHT_NUM, 23331: total weights; lanes whose index is >= WEIGHT_NUM are masked.
- IDXW, 15: index width, $clog2(WEIGHT_NUM).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  batch offered
- in_ready  out  1  batch accepted when in_valid & in_ready at a rising edge
- in_hits  in  LANES  match bit per lane
- in_base  in  IDXW  global weight index of lane 0
- in_last  in  1  final batch of the string
- out_valid  out  1  out_index valid
- out_ready  in  1  consumer takes index when out_valid & out_ready
- out_index  out  IDXW  global index of a matched weight
- hit_total  out  IDXW+1  indices emitted since the run started
- done  out  1  one-cycle pulse when the last batch has fully drained

Behaviour:
- Reset (asynchronous, any state): FIFO empty, scanner IDLE, mask=0, out_valid=0, out_index=0, hit_total=0, done=0, in_ready=1.
- Capture: in_ready = !fifo_full (2 entries).
  - On accept, store {in_hits & lane_mask, in_base, in_last}.
  - lane_mask[k] = (in_base + k < WEIGHT_NUM), computed at IDXW+1 bits so it cannot wrap.
  - Simultaneous push and pop in the same cycle is legal when full; in_ready still reflects the pre-edge full state.
- Scanner FSM:
  - IDLE: FIFO non-empty -> load head mask/base/last into the scan registers, pop the head, go to SCAN.
  - SCAN: pos = index of the lowest set bit of mask (priority encode).
    - out_valid = (mask != 0); out_index = base + pos.
    - On an out_valid & out_ready handshake: clear that bit and increment hit_total.
    - When mask == 0 (either at load time or after clearing the final bit): if last, pulse done for one cycle; go to IDLE.
    - An all-zero batch therefore spends exactly 1 SCAN cycle with out_valid=0.
- Latency: a batch accepted at edge t is loaded at edge t+1 (if the scanner is IDLE); its first index is valid after edge t+1. Throughput is 1 index per cycle when out_ready=1.
- Ordering: indices are emitted in ascending order within a batch and in batch-acceptance order across batches.
- out_valid/out_index hold stable while out_valid & !out_ready.
- done is asserted the cycle after the final handshake of the last batch, or the cycle after loading an empty last batch.
- hit_total clears to 0 on the first batch accepted after done. hit_total saturates at all-ones and never wraps.
- Batches after in_last are the next run; there is no interaction with the previous run beyond the hit_total clear.
- Reset mid-scan: all buffered batches are discarded, no done pulse, hit_total=0.

Optional Feature:
- Macro: MATCH_DRAIN_ZERO_SKIP_EN.
- Defined:
  - A batch whose masked hits are all zero and in_last=0 is accepted (in_ready unaffected) but not pushed into the FIFO.
  - An empty batch with in_last=1 is pushed normally so that done still fires.
- Undefined: every accepted batch is pushed and occupies 1 SCAN cycle.

Test Plan:
- Base case: base=0, hits bits {0,5,255}, last=1, out_ready=1 -> indices 0,5,255 on 3 consecutive cycles; hit_total=3; done the cycle after 255.
- Backpressure: same batch, out_ready toggling 1,0,0,1,1 -> index 5 held stable through both stall cycles; order unchanged; hit_total=3.
- Tail mask: base=23296, hits all ones, last=1 -> exactly 35 indices (23296..23330), none >= 23331; hit_total=35; done.
- Empty last batch: hits=0, last=1 -> out_valid never rises; done pulses 2 cycles after accept; hit_total=0.
  - With MATCH_DRAIN_ZERO_SKIP_EN: a preceding empty non-last batch leaves the FIFO count unchanged.
- Full FIFO: out_ready=0, three batches offered back-to-back -> scanner holds batch 0; batches 1 and 2 fill the FIFO; the next offer sees in_ready=0 until the first pop.
- Mid-scan reset: assert reset after 2 of 4 indices -> out_valid=0 and in_ready=1 immediately (async); no done pulse; hit_total=0; the next batch starts cleanly from index order.
